// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte with inhibit, start, 8 data LSB-first, odd parity, stop, ACK.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tx_data, tx_start   byte and one-cycle request (ignored while busy)
//   tx_busy             high from accept through done/error cycle
//   tx_done, tx_error   one-cycle completion pulses
//   ps2_clk_in/dat_in   raw open-drain pin levels (asynchronous)
//   ps2_clk_oe/dat_oe   1 = pull the line low
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned START_HOLD     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned FW =
    (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] STA_LAST = 32'(START_HOLD - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_FAIL
  } state_t;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          clk_fall;

  state_t      state, state_n;
  logic [31:0] timer, timer_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [9:0]  shreg, shreg_n;
  logic        clk_oe_n, dat_oe_n;
  logic        busy_n, done_n, err_n;
  logic        tmo;

  // The filtered clock only follows the synchronized pin after
  // FILTER_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
      clk_fall <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        clk_fall <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
      tx_error   <= err_n;
    end
  end

  assign tmo = (timer == TMO_LAST);

  // Failure transitions raise tx_error together with entering S_FAIL,
  // so the pulse lines up with the last busy cycle.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    clk_oe_n  = 1'b0;
    dat_oe_n  = 1'b0;
    busy_n    = tx_busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (tx_start && !tx_busy) begin
          shreg_n  = {1'b1, ~^tx_data, tx_data};
          timer_n  = '0;
          clk_oe_n = 1'b1;
          busy_n   = 1'b1;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_n = 1'b1;
        timer_n  = timer + 32'd1;
        if (timer == INH_LAST) begin
          timer_n  = '0;
          dat_oe_n = 1'b1;
          state_n  = S_START;
        end
      end
      S_START: begin
        clk_oe_n = 1'b1;
        dat_oe_n = 1'b1;
        timer_n  = timer + 32'd1;
        if (timer == STA_LAST) begin
          clk_oe_n  = 1'b0;
          timer_n   = '0;
          bit_cnt_n = '0;
          state_n   = S_SEND;
        end
      end
      S_SEND: begin
        dat_oe_n = ps2_dat_oe;
        timer_n  = timer + 32'd1;
        if (tmo) begin
          dat_oe_n = 1'b0;
          err_n    = 1'b1;
          state_n  = S_FAIL;
        end else if (clk_fall) begin
          dat_oe_n  = ~shreg[0];
          shreg_n   = {1'b1, shreg[9:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            state_n = S_ACK;
          end
        end
      end
      S_ACK: begin
        timer_n = timer + 32'd1;
        if (tmo) begin
          err_n   = 1'b1;
          state_n = S_FAIL;
        end else if (clk_fall) begin
          if (!dat_s2) begin
            state_n = S_WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_FAIL;
          end
        end
      end
      S_WAIT_IDLE: begin
        timer_n = timer + 32'd1;
        if (tmo) begin
          err_n   = 1'b1;
          state_n = S_FAIL;
        end else if (clk_filt && dat_s2) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_FAIL: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: random and directed PS/2 host transmit checks
// against a behavioural keyboard model on the shared open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 200;
  localparam int unsigned SH   = 20;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned FL   = 8;
  localparam int          HALF = 40;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;
  localparam int M_GLITCH = 3;
  localparam int M_ABORT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       glitch = 1'b0;

  assign ps2_clk_in = dev_clk & ~glitch & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_HOLD(SH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  int   n_done = 0;
  int   n_err  = 0;
  int   n_inh  = 0;
  logic oe_d   = 1'b0;

  always @(negedge clk) begin
    n_done += int'(tx_done);
    n_err  += int'(tx_error);
    if (ps2_clk_oe && !oe_d) n_inh++;
    oe_d = ps2_clk_oe;
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [10:0] dev_bits;
  int          dev_hold, dev_lag, dev_tmo;

  // Keyboard side: measures the host request, then clocks the frame,
  // reading each bit while its clock is high.
  task automatic dev_xfer(input int mode);
    int k;
    dev_bits = '1;
    dev_hold = 0;
    dev_lag  = 0;
    dev_tmo  = 0;
    k = 0;
    while (!ps2_clk_oe && k < 100) begin
      k++;
      @(negedge clk);
    end
    while (ps2_clk_oe && dev_hold < 10000) begin
      dev_hold++;
      if (!ps2_dat_oe) dev_lag++;
      @(negedge clk);
    end
    dev_bits[0] = ps2_dat_in;
    if (mode == M_SILENT) begin
      while (!tx_error && dev_tmo < 10000) begin
        dev_tmo++;
        @(negedge clk);
      end
      return;
    end
    wait_cyc(10);
    for (int e = 1; e <= 10; e++) begin
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      dev_bits[e] = ps2_dat_in;
      if (mode == M_GLITCH && e == 4) begin
        wait_cyc(10);
        glitch = 1'b1;
        wait_cyc(3);
        glitch = 1'b0;
        wait_cyc(HALF - 13);
      end else begin
        wait_cyc(HALF);
      end
      if (mode == M_ABORT && e == 4) return;
    end
    if (mode != M_NACK) dev_dat = 1'b0;
    wait_cyc(5);
    dev_clk = 1'b0;
    wait_cyc(HALF);
    dev_clk = 1'b1;
    wait_cyc(5);
    dev_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("accept", {tx_busy, ps2_clk_oe}, 2'b11);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (tx_busy && k < 3000) begin
      k++;
      @(negedge clk);
    end
    chk("busy_release", tx_busy, 0);
  endtask

  task automatic run_xfer(input logic [7:0] b,
                          input int mode,
                          input bit poke);
    int  d0;
    int  e0;
    bit  ok;
    d0 = n_done;
    e0 = n_err;
    ok = (mode == M_ACK || mode == M_GLITCH);
    send(b);
    if (poke) begin
      fork
        dev_xfer(mode);
        begin
          wait_cyc(300);
          tx_data  = 8'hAA;
          tx_start = 1'b1;
          wait_cyc(1);
          tx_start = 1'b0;
        end
      join
    end else begin
      dev_xfer(mode);
    end
    wait_idle();
    chk("clk_hold", dev_hold, INH + SH);
    chk("dat_lag", dev_lag, INH);
    if (mode == M_SILENT) chk("timeout", dev_tmo, TMO);
    else chk("frame", dev_bits, exp_frame(b));
    chk("done_cnt", n_done - d0, ok ? 1 : 0);
    chk("err_cnt", n_err - e0, ok ? 0 : 1);
    chk("oe_end", {ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin
    int i0, d0, e0;
    logic [7:0] b;
    int mode;

    wait_cyc(3);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_error, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    reset = 1'b0;
    wait_cyc(20);

    run_xfer(8'hED, M_ACK, 1'b0);
    wait_cyc(20);

    i0 = n_inh;
    run_xfer(8'hFF, M_ACK, 1'b1);
    run_xfer(8'h01, M_ACK, 1'b0);
    wait_cyc(300);
    chk("frames", n_inh - i0, 2);

    run_xfer(8'h5A, M_NACK, 1'b0);
    wait_cyc(20);
    run_xfer(8'h3C, M_SILENT, 1'b0);
    wait_cyc(20);
    run_xfer(8'hF4, M_GLITCH, 1'b0);
    wait_cyc(20);

    d0 = n_done;
    e0 = n_err;
    send(8'hF4);
    dev_xfer(M_ABORT);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_clk_oe", ps2_clk_oe, 0);
    chk("abort_dat_oe", ps2_dat_oe, 0);
    chk("abort_busy", tx_busy, 0);
    wait_cyc(100);
    chk("abort_done", n_done - d0, 0);
    chk("abort_err", n_err - e0, 0);
    run_xfer(8'hF4, M_ACK, 1'b0);

    for (int r = 0; r < 5; r++) begin
      wait_cyc(20);
      b    = 8'($urandom);
      mode = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
      run_xfer(b, mode, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
